// File: rtl/adder_result_drain.sv
// Ping-pong drain for the adder array: buffers two result vectors and streams sums one channel per valid/ready transfer.
// `DRAIN_RELU_EN` clamps negative sums to zero on the output only; buffered data stays raw.
module adder_result_drain #(
  parameter int DATA_WIDTH = 14,
  parameter int NUM_ADDERS = 16,
  parameter int CH_W       = $clog2(NUM_ADDERS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_ADDERS*DATA_WIDTH-1:0] adder_outputs,
  input  logic [NUM_ADDERS-1:0]            output_valids,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CH_W-1:0]                  out_channel,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             overflow,
  output logic                             misalign
);

  logic [DATA_WIDTH-1:0] bank [2][NUM_ADDERS];
  logic                  wp;
  logic                  rp;
  logic [1:0]            cnt;
  logic [CH_W-1:0]       ch;
  logic                  overflow_q;
  logic                  misalign_q;

  logic                  all_vld;
  logic                  any_vld;
  logic                  xfer;
  logic                  is_last;
  logic                  release_bank;
  logic                  accept;
  logic [DATA_WIDTH-1:0] raw;

  assign all_vld      = &output_valids;
  assign any_vld      = |output_valids;
  assign xfer         = out_valid & out_ready;
  assign is_last      = (ch == CH_W'(NUM_ADDERS - 1));
  assign release_bank = xfer & is_last;
  // A full store can still take a vector when the drained bank frees up on this same edge.
  assign accept       = all_vld & ((cnt != 2'd2) | release_bank);
  assign raw          = bank[rp][ch];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_ADDERS; i++) begin
          bank[b][i] <= '0;
        end
      end
      wp         <= 1'b0;
      rp         <= 1'b0;
      cnt        <= 2'd0;
      ch         <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NUM_ADDERS; i++) begin
          bank[wp][i] <= adder_outputs[i*DATA_WIDTH +: DATA_WIDTH];
        end
        wp <= ~wp;
      end
      if (xfer) begin
        if (is_last) begin
          ch <= '0;
          rp <= ~rp;
        end else begin
          ch <= ch + 1'b1;
        end
      end
      case ({accept, release_bank})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (all_vld && !accept) begin
        overflow_q <= 1'b1;
      end
      if (any_vld && !all_vld) begin
        misalign_q <= 1'b1;
      end
    end
  end

  assign out_valid   = (cnt != 2'd0);
  assign out_channel = ch;
  assign out_last    = is_last;
  assign overflow    = overflow_q;
  assign misalign    = misalign_q;

`ifdef DRAIN_RELU_EN
  assign out_data = raw[DATA_WIDTH-1] ? '0 : raw;
`else
  assign out_data = raw;
`endif

endmodule

// File: tb/tb_adder_result_drain.sv
// Randomized bench for adder_result_drain against a queue-of-vectors model, plus directed literal checks.
module tb_adder_result_drain;
  localparam int N  = 16;
  localparam int W  = 14;
  localparam int CW = $clog2(N);

  logic             clk;
  logic             reset;
  logic [N*W-1:0]   adder_outputs;
  logic [N-1:0]     output_valids;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    out_channel;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             misalign;

  int total = 0;
  int bad   = 0;

  // Model: queue of whole vectors awaiting drain, position within the head vector.
  logic [N*W-1:0] mq[$];
  int             pos;
  logic           m_ovf;
  logic           m_mis;

  adder_result_drain #(.DATA_WIDTH(W), .NUM_ADDERS(N)) dut (
    .clk(clk), .reset(reset), .adder_outputs(adder_outputs), .output_valids(output_valids),
    .out_data(out_data), .out_channel(out_channel), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] relu(input logic [W-1:0] x);
`ifdef DRAIN_RELU_EN
    return x[W-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [N*W-1:0] mkvec(input int base);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(base + i);
    return v;
  endfunction

  function automatic void check_model();
    logic [N*W-1:0] head;
    chk("valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      head = mq[0];
      chk("data", 32'(out_data), 32'(relu(head[pos*W +: W])));
      chk("channel", 32'(out_channel), 32'(pos));
      chk("last", 32'(out_last), 32'(pos == N-1));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("misalign", 32'(misalign), 32'(m_mis));
  endfunction

  function automatic void model_step(input logic [N*W-1:0] d, input logic [N-1:0] v,
                                     input logic r, input logic rst);
    logic xf, rel, full, acc;
    if (rst) begin
      mq.delete();
      pos   = 0;
      m_ovf = 1'b0;
      m_mis = 1'b0;
      return;
    end
    xf   = (mq.size() != 0) && r;
    rel  = xf && (pos == N-1);
    full = &v;
    acc  = full && ((mq.size() < 2) || rel);
    if (full && !acc) m_ovf = 1'b1;
    if ((v != '0) && !full) m_mis = 1'b1;
    if (xf) begin
      if (rel) begin
        pos = 0;
        void'(mq.pop_front());
      end else begin
        pos++;
      end
    end
    if (acc) mq.push_back(d);
  endfunction

  // Called at a falling edge: check, drive, advance model, then move to the next falling edge.
  task automatic cyc(input logic [N*W-1:0] d, input logic [N-1:0] v, input logic r, input logic rst);
    check_model();
    adder_outputs = d;
    output_valids = v;
    out_ready     = r;
    reset         = rst;
    model_step(d, v, r, rst);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    adder_outputs = '0;
    output_valids = '0;
    out_ready     = 1'b0;
    reset         = 1'b1;
    model_step('0, '0, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   v;
    logic           r;
    logic           rst;
    int             sel;

    pos = 0; m_ovf = 1'b0; m_mis = 1'b0;
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_channel", 32'(out_channel), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_misalign", 32'(misalign), 0);

    // Single vector 1..16 with ready high.
    cyc(mkvec(1), '1, 1'b1, 1'b0);
    chk("first_valid", 32'(out_valid), 1);
    for (int k = 0; k < N; k++) begin
      chk("seq_data", 32'(out_data), 32'(k + 1));
      chk("seq_channel", 32'(out_channel), 32'(k));
      chk("seq_last", 32'(out_last), 32'(k == N-1));
      cyc('0, '0, 1'b1, 1'b0);
    end
    chk("drained_valid", 32'(out_valid), 0);

    // Backpressure: ready toggles, model checks order and stability.
    cyc(mkvec(1), '1, 1'b1, 1'b0);
    for (int k = 0; k < 2*N + 2; k++) cyc('0, '0, 1'(k % 2 == 0), 1'b0);
    chk("bp_done", 32'(out_valid), 0);

    // Overflow: third back-to-back vector is dropped.
    do_reset();
    cyc(mkvec(16'h10), '1, 1'b0, 1'b0);
    cyc(mkvec(16'h20), '1, 1'b0, 1'b0);
    cyc(mkvec(16'h30), '1, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    for (int k = 0; k < 2*N; k++) begin
      chk("ovf_drain", 32'(out_data), 32'((k < N) ? 16'h10 + k : 16'h20 + k - N));
      cyc('0, '0, 1'b1, 1'b0);
    end
    chk("ovf_empty", 32'(out_valid), 0);

    // Capture on the cycle the last channel transfers while full.
    do_reset();
    cyc(mkvec(16'h40), '1, 1'b0, 1'b0);
    cyc(mkvec(16'h50), '1, 1'b0, 1'b0);
    for (int k = 0; k < N-1; k++) cyc('0, '0, 1'b1, 1'b0);
    chk("rel_last", 32'(out_last), 1);
    cyc(mkvec(16'h60), '1, 1'b1, 1'b0);
    chk("rel_no_ovf", 32'(overflow), 0);
    chk("rel_next", 32'(out_data), 32'(16'h50));
    for (int k = 0; k < 2*N; k++) cyc('0, '0, 1'b1, 1'b0);
    chk("rel_empty", 32'(out_valid), 0);

    // Partial valids.
    do_reset();
    cyc(mkvec(7), 16'h00FF, 1'b1, 1'b0);
    chk("mis_set", 32'(misalign), 1);
    chk("mis_novalid", 32'(out_valid), 0);
    do_reset();
    chk("mis_clear", 32'(misalign), 0);

    // Sign handling of a negative sum.
    d = mkvec(4);
    d[0 +: W] = 14'h3FFF;
    d[W +: W] = 14'd5;
    cyc(d, '1, 1'b1, 1'b0);
`ifdef DRAIN_RELU_EN
    chk("relu_neg", 32'(out_data), 0);
`else
    chk("raw_neg", 32'(out_data), 32'(14'h3FFF));
`endif
    cyc('0, '0, 1'b1, 1'b0);
    chk("relu_pos", 32'(out_data), 5);
    for (int k = 0; k < N; k++) cyc('0, '0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
      sel = $urandom_range(0, 99);
      if (sel < 5)      v = '1;
      else if (sel < 6) v = N'($urandom);
      else              v = '0;
      r   = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 399) == 0);
      cyc(d, v, r, rst);
    end
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
